// File: rtl/hsid_pkg.sv
// Shared types and sizing constants for the hsid FIFO datapath.
// The reader sequencer state type lives here so checkers and benches can decode it.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH       = 16;
    localparam int HSID_FIFO_ADDR_WIDTH  = 4;
    localparam int HSID_REPEAT_WIDTH     = 8;
    localparam int HSID_READER_BUF_DEPTH = 3;

    typedef enum logic [1:0] {
        RDR_IDLE   = 2'd0,
        RDR_STREAM = 2'd1,
        RDR_DRAIN  = 2'd2,
        RDR_DONE   = 2'd3
    } hsid_fifo_reader_state_t;

endpackage

// File: rtl/hsid_fifo_reader_sva.sv
// Protocol checker for hsid_fifo_reader; bound onto the reader from the bench.
// Covers request exclusivity, buffer overflow and output stability under backpressure.
module hsid_fifo_reader_sva #(
    parameter int WORD_WIDTH = 16,
    parameter int BUF_DEPTH  = 3,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  fifo_rd_en,
    input logic                  fifo_loop_en,
    input logic                  fifo_clear,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [WORD_WIDTH-1:0] out_data,
    input logic                  out_last,
    input logic                  buf_push,
    input logic [CNT_W-1:0]      buf_count
);

    a_req_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_loop_en));

    a_no_req_on_clear: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_clear |-> !(fifo_rd_en || fifo_loop_en));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (buf_push && !(out_valid && out_ready)) |-> (buf_count < CNT_W'(BUF_DEPTH)));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !fifo_clear) |=>
            (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: rtl/hsid_reader_buf.sv
// Small {last, data} output buffer for the hsid FIFO reader.
// Circular storage with a valid/ready pop side and an occupancy count.
module hsid_reader_buf
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH = HSID_WORD_WIDTH,
    parameter int DEPTH      = HSID_READER_BUF_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop_ready,
    output logic                  pop_valid,
    output logic [WORD_WIDTH-1:0] pop_data,
    output logic                  pop_last,
    output logic [CNT_W-1:0]      count
);

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WORD_WIDTH:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                pop_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            ptr_next = PTR_ZERO;
        end else begin
            ptr_next = ptr + PTR_ONE;
        end
    endfunction

    assign pop_valid             = (count_r != CNT_ZERO);
    assign pop_s                 = pop_valid && pop_ready;
    assign {pop_last, pop_data}  = mem_r[rd_ptr_r];
    assign count                 = count_r;

    // Storage, pointers and occupancy; srst empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(WORD_WIDTH + 1){1'b0}};
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (srst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= {push_last, push_data};
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hsid_fifo_reader.sv
// Read-side sequencer for the hsid FIFO: streams a stored vector repeat_count times,
// recirculating through loop reads on every pass except the last.
module hsid_fifo_reader
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
    parameter int FIFO_ADDR_WIDTH = HSID_FIFO_ADDR_WIDTH,
    parameter int REPEAT_WIDTH    = HSID_REPEAT_WIDTH,
    parameter int BUF_DEPTH       = HSID_READER_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [FIFO_ADDR_WIDTH:0] vector_len,
    input  logic [REPEAT_WIDTH-1:0]  repeat_count,
    input  logic                     fifo_empty,
    input  logic [WORD_WIDTH-1:0]    fifo_data_out,
    output logic                     fifo_rd_en,
    output logic                     fifo_loop_en,
    output logic                     fifo_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [FIFO_ADDR_WIDTH:0] LEN_ZERO = {(FIFO_ADDR_WIDTH + 1){1'b0}};
    localparam logic [FIFO_ADDR_WIDTH:0] LEN_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [REPEAT_WIDTH-1:0]  REP_ZERO = {REPEAT_WIDTH{1'b0}};
    localparam logic [REPEAT_WIDTH-1:0]  REP_ONE  = {{(REPEAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]           ROOM_MAX = (CNT_W + 1)'(BUF_DEPTH);

    hsid_fifo_reader_state_t state_r, state_nxt_s;

    logic [FIFO_ADDR_WIDTH:0] len_r, word_cnt_r;
    logic [REPEAT_WIDTH-1:0]  rep_r, pass_cnt_r;
    logic                     req_d_r, last_d_r;
    logic [CNT_W-1:0]         buf_count_s, occ_s;
    logic                     push_s, pop_s, issue_s, accept_s, room_s;
    logic                     final_pass_s, last_word_s;

    assign last_word_s  = ((word_cnt_r + LEN_ONE) == len_r);
    assign final_pass_s = ((pass_cnt_r + REP_ONE) == rep_r);
    // A word leaving the buffer this cycle already frees its slot for a new request.
    assign pop_s        = out_valid && out_ready;
    assign occ_s        = buf_count_s - CNT_W'(pop_s);
    assign room_s       = (({1'b0, occ_s} + (CNT_W + 1)'(req_d_r)) < ROOM_MAX);
    assign push_s       = req_d_r && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RDR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, FIFO request and status decode; abort overrides everything.
    always_comb begin
        state_nxt_s  = state_r;
        issue_s      = 1'b0;
        accept_s     = 1'b0;
        fifo_rd_en   = 1'b0;
        fifo_loop_en = 1'b0;
        fifo_clear   = 1'b0;
        busy         = (state_r != RDR_IDLE);
        done         = (state_r == RDR_DONE) && !abort;
        if (abort) begin
            fifo_clear  = 1'b1;
            state_nxt_s = RDR_IDLE;
        end else begin
            case (state_r)
                RDR_IDLE: begin
                    if (start && (|vector_len) && (|repeat_count)) begin
                        accept_s    = 1'b1;
                        state_nxt_s = RDR_STREAM;
                    end else begin
                        state_nxt_s = RDR_IDLE;
                    end
                end
                RDR_STREAM: begin
                    if (!fifo_empty && room_s) begin
                        issue_s      = 1'b1;
                        fifo_rd_en   = final_pass_s;
                        fifo_loop_en = !final_pass_s;
                        if (final_pass_s && last_word_s) begin
                            state_nxt_s = RDR_DRAIN;
                        end else begin
                            state_nxt_s = RDR_STREAM;
                        end
                    end else begin
                        state_nxt_s = RDR_STREAM;
                    end
                end
                RDR_DRAIN: begin
                    if (!req_d_r && (buf_count_s == {CNT_W{1'b0}})) begin
                        state_nxt_s = RDR_DONE;
                    end else begin
                        state_nxt_s = RDR_DRAIN;
                    end
                end
                RDR_DONE: begin
                    state_nxt_s = RDR_IDLE;
                end
                default: begin
                    state_nxt_s = RDR_IDLE;
                end
            endcase
        end
    end

    // Configuration latch plus word/pass counters advanced per issued request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r      <= LEN_ZERO;
            rep_r      <= REP_ZERO;
            word_cnt_r <= LEN_ZERO;
            pass_cnt_r <= REP_ZERO;
        end else if (accept_s) begin
            len_r      <= vector_len;
            rep_r      <= repeat_count;
            word_cnt_r <= LEN_ZERO;
            pass_cnt_r <= REP_ZERO;
        end else if (issue_s) begin
            if (last_word_s) begin
                word_cnt_r <= LEN_ZERO;
                pass_cnt_r <= pass_cnt_r + REP_ONE;
            end else begin
                word_cnt_r <= word_cnt_r + LEN_ONE;
            end
        end
    end

    // One-cycle request pipeline: read data (and its last tag) arrive the cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_r  <= 1'b0;
            last_d_r <= 1'b0;
        end else begin
            req_d_r  <= issue_s;
            last_d_r <= issue_s && last_word_s;
        end
    end

    hsid_reader_buf #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .srst      (abort),
        .push      (push_s),
        .push_data (fifo_data_out),
        .push_last (last_d_r),
        .pop_ready (out_ready),
        .pop_valid (out_valid),
        .pop_data  (out_data),
        .pop_last  (out_last),
        .count     (buf_count_s)
    );

endmodule

// File: tb/tb_hsid_fifo_reader.sv
// Directed bench for hsid_fifo_reader with a behavioural hsid FIFO model driven per clock.
module tb_hsid_fifo_reader;
    import hsid_pkg::*;

    localparam int WW  = HSID_WORD_WIDTH;
    localparam int FAW = HSID_FIFO_ADDR_WIDTH;
    localparam int RW  = HSID_REPEAT_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, fifo_empty, out_ready;
    logic [FAW:0]  vector_len;
    logic [RW-1:0] repeat_count;
    logic [WW-1:0] fifo_data_out, out_data;
    logic          fifo_rd_en, fifo_loop_en, fifo_clear, out_valid, out_last, busy, done;

    always #5 clk = ~clk;

    hsid_fifo_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vector_len(vector_len), .repeat_count(repeat_count),
        .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_rd_en(fifo_rd_en), .fifo_loop_en(fifo_loop_en), .fifo_clear(fifo_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    bind hsid_fifo_reader hsid_fifo_reader_sva #(.WORD_WIDTH(WORD_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_sva (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_loop_en(fifo_loop_en),
        .fifo_clear(fifo_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .buf_push(push_s), .buf_count(buf_count_s)
    );

    int checks = 0;
    int failures = 0;

    logic [WW-1:0] fq[$];
    logic [WW-1:0] late_q[$];
    logic [WW:0]   xq[$];
    int            xc[$];
    int rd_cnt, loop_cnt, clear_cnt, req_total, proto_err;
    int cyc = 0, start_cyc = 0, rel = 0;
    int xfer_total, done_cnt, done_rel, max_out, stab_err;
    int ready_mode = 0, abort_at = -1, late_at = -1;
    bit busy_seen, stalled_prev, abort_prev;
    bit valid_hist[64];
    bit busy_hist[64];
    logic [WW:0] prev_word;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic load_words(input logic [WW-1:0] base, input int n);
        for (int i = 0; i < n; i++) push_word(base + WW'(i));
    endtask

    // hsid FIFO behaviour at the active edge: loop reads recirculate, clear empties.
    task automatic model_step();
        logic [WW-1:0] w;
        if (fifo_rd_en && fifo_loop_en) proto_err++;
        if (fifo_clear) begin
            clear_cnt++;
            if (fifo_rd_en || fifo_loop_en) proto_err++;
            fq.delete();
        end else if (fifo_rd_en || fifo_loop_en) begin
            req_total++;
            if (fifo_rd_en) rd_cnt++;
            else begin
                if (rd_cnt != 0) proto_err++;
                loop_cnt++;
            end
            if (fq.size() == 0) proto_err++;
            else begin
                w = fq.pop_front();
                fifo_data_out <= w;
                if (!fifo_rd_en) fq.push_back(w);
            end
        end
        fifo_empty <= (fq.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        rel = cyc - start_cyc;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((rel % 4) == 0) || ((rel % 4) == 3);
            default: out_ready = 1'b0;
        endcase
        if (rel >= 0 && rel < 64) begin
            valid_hist[rel] = out_valid;
            busy_hist[rel]  = busy;
        end
        if (busy) busy_seen = 1'b1;
        if (req_total - xfer_total > max_out) max_out = req_total - xfer_total;
        if (stalled_prev && !abort_prev) begin
            if (!out_valid || ({out_last, out_data} !== prev_word)) stab_err++;
        end
        if (out_valid && out_ready) begin
            xq.push_back({out_last, out_data});
            xc.push_back(rel);
            xfer_total++;
        end
        stalled_prev = out_valid && !out_ready;
        prev_word    = {out_last, out_data};
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        abort = (rel == abort_at);
        abort_prev = abort;
        if (rel == late_at) begin
            while (late_q.size() > 0) push_word(late_q.pop_front());
        end
    endtask

    task automatic run_job(input int len, input int rep, input int budget);
        xq.delete(); xc.delete();
        rd_cnt = 0; loop_cnt = 0; clear_cnt = 0; req_total = 0; proto_err = 0;
        xfer_total = 0; done_cnt = 0; done_rel = -1; max_out = 0; stab_err = 0;
        busy_seen = 1'b0; stalled_prev = 1'b0; abort_prev = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid_hist[i] = 1'b0;
            busy_hist[i]  = 1'b0;
        end
        vector_len   = len[FAW:0];
        repeat_count = rep[RW-1:0];
        start        = 1'b1;
        start_cyc    = cyc;
        tick();
        start = 1'b0;
        for (int i = 1; i < budget; i++) tick();
    endtask

    task automatic check_stream(input string tag, input int n, input logic [WW-1:0] base, input int len);
        logic [WW:0] exp;
        check_value({tag, "_count"}, xq.size(), n);
        for (int i = 0; i < n && i < xq.size(); i++) begin
            exp = {((i % len) == len - 1), base + WW'(i % len)};
            check_value($sformatf("%s_word%0d", tag, i), xq[i], exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        vector_len = '0; repeat_count = '0; fifo_empty = 1'b1; fifo_data_out = '0;
        repeat (2) @(negedge clk);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_out_data", out_data, 0);
        check_value("rst_out_last", out_last, 0);
        check_value("rst_rd_loop_clr", {fifo_rd_en, fifo_loop_en, fifo_clear}, 0);
        check_value("rst_busy_done", {busy, done}, 0);
        rst_n = 1'b1;
        tick();

        // single pass, plain reads
        load_words(16'hA000, 4);
        run_job(4, 1, 12);
        check_stream("t1", 4, 16'hA000, 4);
        for (int i = 0; i < 4 && i < xc.size(); i++) check_value($sformatf("t1_cycle%0d", i), xc[i], i + 3);
        check_value("t1_done_cnt", done_cnt, 1);
        check_value("t1_done_cycle", done_rel, 8);
        check_value("t1_rd_cnt", rd_cnt, 4);
        check_value("t1_loop_cnt", loop_cnt, 0);
        check_value("t1_fifo_left", fq.size(), 0);
        check_value("t1_busy_end", busy, 0);
        check_value("t1_proto", proto_err, 0);

        // three passes: loop, loop, read
        load_words(16'hB000, 3);
        run_job(3, 3, 25);
        check_stream("t2", 9, 16'hB000, 3);
        check_value("t2_loop_cnt", loop_cnt, 6);
        check_value("t2_rd_cnt", rd_cnt, 3);
        check_value("t2_done_cnt", done_cnt, 1);
        check_value("t2_done_cycle", done_rel, 13);
        check_value("t2_fifo_left", fq.size(), 0);
        check_value("t2_proto", proto_err, 0);

        // backpressure 1,0,0,1
        ready_mode = 1;
        load_words(16'hC000, 4);
        run_job(4, 2, 45);
        ready_mode = 0;
        check_stream("t3", 8, 16'hC000, 4);
        check_value("t3_stable", stab_err, 0);
        check_value("t3_max_outstanding", max_out, 3);
        check_value("t3_loop_rd", {loop_cnt[7:0], rd_cnt[7:0]}, {8'd4, 8'd4});
        check_value("t3_done_cnt", done_cnt, 1);

        // FIFO runs dry after two words, the rest arrive later
        load_words(16'hD000, 2);
        late_q.push_back(16'hD002);
        late_q.push_back(16'hD003);
        late_at = 5;
        run_job(4, 1, 16);
        late_at = -1;
        check_stream("t4", 4, 16'hD000, 4);
        if (xc.size() == 4) check_value("t4_last_cycle", xc[3], 8);
        check_value("t4_done_cycle", done_rel, 10);
        check_value("t4_done_cnt", done_cnt, 1);
        check_value("t4_proto", proto_err, 0);

        // abort while the second word is presented
        load_words(16'hE000, 4);
        abort_at = 4;
        run_job(4, 1, 12);
        abort_at = -1;
        check_value("t5_xfers", xq.size(), 2);
        check_value("t5_clear_cnt", clear_cnt, 1);
        check_value("t5_valid_at4", valid_hist[4], 1);
        check_value("t5_valid_at5", valid_hist[5], 0);
        check_value("t5_busy_at5", busy_hist[5], 0);
        check_value("t5_no_done", done_cnt, 0);
        check_value("t5_rd_cnt", rd_cnt, 3);
        check_value("t5_fifo_left", fq.size(), 0);
        check_value("t5_proto", proto_err, 0);

        // a fresh start is accepted after abort
        load_words(16'hF000, 2);
        run_job(2, 1, 12);
        check_stream("t6", 2, 16'hF000, 2);
        check_value("t6_done_cycle", done_rel, 6);

        // zero repeat_count / zero vector_len are ignored
        load_words(16'h1000, 2);
        run_job(2, 0, 10);
        check_value("t7a_reqs", req_total, 0);
        check_value("t7a_busy", busy_seen, 0);
        check_value("t7a_done", done_cnt, 0);
        run_job(0, 1, 10);
        check_value("t7b_reqs", req_total, 0);
        check_value("t7b_busy", busy_seen, 0);
        check_value("t7b_done", done_cnt, 0);
        fq.delete();
        fifo_empty = 1'b1;

        // asynchronous reset mid-stream with a full buffer
        ready_mode = 2;
        load_words(16'h2000, 4);
        run_job(4, 1, 5);
        check_value("t8_valid_before", out_valid, 1);
        check_value("t8_data_before", out_data, 16'h2000);
        #2 rst_n = 1'b0;
        #1;
        check_value("t8_async_valid", out_valid, 0);
        check_value("t8_async_data", out_data, 0);
        check_value("t8_async_ctrl", {fifo_rd_en, fifo_loop_en, fifo_clear, busy, done, out_last}, 0);
        tick();
        rst_n = 1'b1;
        ready_mode = 0;
        fq.delete();
        fifo_empty = 1'b1;
        tick();
        check_value("t8_idle_busy", busy, 0);
        check_value("t8_idle_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
